cva6_axi_mem_responder: RTL and testbench
=========================================

# cva6_axi_mem_responder

AXI4 subordinate that terminates the core-side AXI4 master port with a flip-flop memory, for simulation harnesses and small on-chip scratchpads. Sits directly on the flattened `axi_req_o_*`/`axi_resp_i_*` signals, after the atomics adapter, so it never sees ATOPs. It serves one transaction at a time, supports FIXED/INCR/WRAP bursts with byte strobes, and returns DECERR outside its window.

## Interface
- AXI_ADDRESS_WIDTH, 64: address width.
- AXI_DATA_WIDTH, 64: data width; power of two, ≥32.
- AXI_ID_WIDTH, 4: ID width; IDs are echoed unchanged.
- AXI_USER_WIDTH, 1: user width; user inputs are ignored.
- MEM_BASE, 64'h8000_0000: window base; must be aligned to the window size.
- MEM_WORDS, 1024: depth in data-width words; power of two.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- axi_req_i_aw_{valid,bits_id,addr,len,size,burst,lock,cache,prot,qos,region,user}  in  AXI4 widths  AW channel.
- axi_resp_o_aw_ready  out  1  AW accept.
- axi_req_i_w_{valid,bits_data,strb,last,user}  in  AXI4 widths  W channel.
- axi_resp_o_w_ready  out  1  W accept.
- axi_resp_o_b_{valid,bits_id,bits_resp,bits_user}  out  1/ID/2/USER  B channel.
- axi_req_i_b_ready  in  1  B accept.
- axi_req_i_ar_{valid,bits_*}  in  AXI4 widths  AR channel; same fields as AW.
- axi_resp_o_ar_ready  out  1  AR accept.
- axi_resp_o_r_{valid,bits_id,bits_data,bits_resp,bits_last,bits_user}  out  1/ID/DATA/2/1/USER  R channel.
- axi_req_i_r_ready  in  1  R accept.

## Operation
- FSM states: IDLE, WDATA, WRESP, RDATA.
- IDLE: the block asserts aw_ready or ar_ready, never both.
  - If only one channel is valid, that channel is selected.
  - If both are valid, the selection is round-robin: the direction not served last wins. After reset, write has priority.
  - The selected request is registered: id, addr, len, size, burst. The beat counter is cleared.
- WDATA: w_ready=1.
  - Each beat writes the strobed bytes of word ((addr−MEM_BASE)>>log2(DATA/8)) mod MEM_WORDS, but only when in range.
  - The burst ends on beat len+1, then the FSM goes to WRESP.
  - If w_last does not match the beat position (asserted early, or missing on the final beat), the error is recorded. The beat count alone decides termination.
- WRESP: b_valid=1 until b_ready, then IDLE.
  - b_resp priority: DECERR (2'b11) if out of range, else SLVERR (2'b10) on a w_last mismatch, else OKAY.
- RDATA: r_data = word at the current address; r_last on beat len+1.
  - Out of range: r_data=0, r_resp=DECERR.
  - Leaves to IDLE on the last r handshake.
- Range check: done once per burst on the start address, against [MEM_BASE, MEM_BASE+MEM_WORDS·DATA/8).
- Next address, per burst type:
  - FIXED: unchanged.
  - INCR: aligned(addr)+2^size.
  - WRAP: wraps within a boundary of (len+1)·2^size.
  - Burst type 2'b11 (reserved) is treated as INCR.
- Narrow transfers use the address lanes as given. The strobe is trusted, not regenerated.
- lock, cache, prot, qos, region are ignored. Exclusive accesses get OKAY, never EXOKAY.
- b_user and r_user are 0.

## Timing
- Reset values: FSM=IDLE, RR pointer=write. aw_ready, ar_ready, w_ready, b_valid and r_valid are 0 during reset and rise in IDLE the first cycle after reset release. All bits fields are 0.
- AW handshake at cycle N: w_ready=1 from N+1. A W beat presented in the AW handshake cycle is not accepted.
- Write throughput: one W beat per cycle. The final W handshake at M gives b_valid at M+1.
- AR handshake at N: first r_valid at N+1. Further beats are back-to-back while r_ready=1.
- R and B outputs are held stable while valid and not ready.
- IDLE is re-entered the cycle after the B/R completion. The next AW/AR handshake happens no earlier than that cycle.
- Reset mid-burst: the transaction is abandoned, all valids/readys deassert asynchronously, and memory contents are retained. The memory array has no reset.

## Structure
- Package cva6_axi_mem_pkg holds:
  - resp codes (OKAY/EXOKAY/SLVERR/DECERR)
  - burst enum (FIXED/INCR/WRAP)
  - FSM state enum
  - a `beat_addr_t` width helper
- Sub-module axi_burst_addr_gen: purely combinational next-address calculation from (addr, len, size, burst). It is instanced once and shared, since only one burst is active at a time.
- The memory array and FSM live in the top module.

## Test plan
- Single write of 64'hDEAD_BEEF_0123_4567, strb 8'hFF, at 0x8000_0010, then a read at the same address -> b_resp=OKAY, read returns that value with r_last=1 and r_resp=OKAY.
- INCR write, len=3, size=3, at 0x8000_0000, with strb 8'h0F on beat 2 -> a read-back shows beat 2's upper bytes unchanged, and B arrives one cycle after the last W.
- WRAP read, len=3, size=3, at 0x8000_0018 -> beats come from 0x18, 0x00, 0x08, 0x10; the ID is echoed; r_ready is held low two cycles mid-burst with data stable.
- Write at 0x7FFF_FFF8 and read at MEM_BASE+MEM_WORDS·8 -> DECERR on both, memory unchanged, read data 0.
- AW and AR asserted together at reset release, then again together -> write served first, read second. W with w_last on beat 1 of a len=1 burst gives SLVERR.
- Assert rst_ni low mid-read-burst -> r_valid falls immediately, after release the FSM is IDLE, and a new read completes normally.

Source files
------------

// File: rtl/cva6_axi_mem_responder_pkg.sv
// cva6_axi_mem_pkg: shared encodings for the AXI4 flip-flop memory responder.
package cva6_axi_mem_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } burst_t;

    typedef enum logic [1:0] {
        IDLE,
        WDATA,
        WRESP,
        RDATA
    } state_t;

    // Beat counters track AXI4 len, which is 8 bits wide.
    localparam int unsigned AXI_LEN_WIDTH = 8;
    typedef logic [AXI_LEN_WIDTH-1:0] beat_addr_t;

endpackage

// File: rtl/cva6_axi_mem_responder_addr_gen.sv
// axi_burst_addr_gen: combinational AXI4 next-beat address for FIXED/INCR/WRAP bursts.
module axi_burst_addr_gen
    import cva6_axi_mem_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  beat_addr_t            len_i,
    input  logic [2:0]            size_i,
    input  burst_t                burst_i,
    output logic [ADDR_WIDTH-1:0] next_addr_o
);

    logic [ADDR_WIDTH-1:0] step, incr, wrap_mask;

    assign step      = ADDR_WIDTH'(1) << size_i;
    assign incr      = (addr_i & ~(step - ADDR_WIDTH'(1))) + step;
    assign wrap_mask = ((ADDR_WIDTH'(len_i) + ADDR_WIDTH'(1)) << size_i) - ADDR_WIDTH'(1);

    // Anything that is neither FIXED nor WRAP advances like INCR.
    assign next_addr_o = (burst_i == BURST_FIXED) ? addr_i
                       : (burst_i == BURST_WRAP)  ? ((addr_i & ~wrap_mask) | (incr & wrap_mask))
                       : incr;

endmodule

// File: rtl/cva6_axi_mem_responder.sv
// cva6_axi_mem_responder: single-transaction AXI4 subordinate backed by a flip-flop
// memory, answering DECERR for bursts that start outside its window.
module cva6_axi_mem_responder
    import cva6_axi_mem_pkg::*;
#(
    parameter int unsigned                  AXI_ADDRESS_WIDTH = 64,
    parameter int unsigned                  AXI_DATA_WIDTH    = 64,
    parameter int unsigned                  AXI_ID_WIDTH      = 4,
    parameter int unsigned                  AXI_USER_WIDTH    = 1,
    parameter logic [AXI_ADDRESS_WIDTH-1:0] MEM_BASE          = 64'h8000_0000,
    parameter int unsigned                  MEM_WORDS         = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         axi_req_i_aw_valid,
    input  logic [AXI_ID_WIDTH-1:0]      axi_req_i_aw_bits_id,
    input  logic [AXI_ADDRESS_WIDTH-1:0] axi_req_i_aw_bits_addr,
    input  logic [7:0]                   axi_req_i_aw_bits_len,
    input  logic [2:0]                   axi_req_i_aw_bits_size,
    input  logic [1:0]                   axi_req_i_aw_bits_burst,
    input  logic                         axi_req_i_aw_bits_lock,
    input  logic [3:0]                   axi_req_i_aw_bits_cache,
    input  logic [2:0]                   axi_req_i_aw_bits_prot,
    input  logic [3:0]                   axi_req_i_aw_bits_qos,
    input  logic [3:0]                   axi_req_i_aw_bits_region,
    input  logic [AXI_USER_WIDTH-1:0]    axi_req_i_aw_bits_user,
    output logic                         axi_resp_o_aw_ready,
    input  logic                         axi_req_i_w_valid,
    input  logic [AXI_DATA_WIDTH-1:0]    axi_req_i_w_bits_data,
    input  logic [AXI_DATA_WIDTH/8-1:0]  axi_req_i_w_bits_strb,
    input  logic                         axi_req_i_w_bits_last,
    input  logic [AXI_USER_WIDTH-1:0]    axi_req_i_w_bits_user,
    output logic                         axi_resp_o_w_ready,
    output logic                         axi_resp_o_b_valid,
    output logic [AXI_ID_WIDTH-1:0]      axi_resp_o_b_bits_id,
    output logic [1:0]                   axi_resp_o_b_bits_resp,
    output logic [AXI_USER_WIDTH-1:0]    axi_resp_o_b_bits_user,
    input  logic                         axi_req_i_b_ready,
    input  logic                         axi_req_i_ar_valid,
    input  logic [AXI_ID_WIDTH-1:0]      axi_req_i_ar_bits_id,
    input  logic [AXI_ADDRESS_WIDTH-1:0] axi_req_i_ar_bits_addr,
    input  logic [7:0]                   axi_req_i_ar_bits_len,
    input  logic [2:0]                   axi_req_i_ar_bits_size,
    input  logic [1:0]                   axi_req_i_ar_bits_burst,
    input  logic                         axi_req_i_ar_bits_lock,
    input  logic [3:0]                   axi_req_i_ar_bits_cache,
    input  logic [2:0]                   axi_req_i_ar_bits_prot,
    input  logic [3:0]                   axi_req_i_ar_bits_qos,
    input  logic [3:0]                   axi_req_i_ar_bits_region,
    input  logic [AXI_USER_WIDTH-1:0]    axi_req_i_ar_bits_user,
    output logic                         axi_resp_o_ar_ready,
    output logic                         axi_resp_o_r_valid,
    output logic [AXI_ID_WIDTH-1:0]      axi_resp_o_r_bits_id,
    output logic [AXI_DATA_WIDTH-1:0]    axi_resp_o_r_bits_data,
    output logic [1:0]                   axi_resp_o_r_bits_resp,
    output logic                         axi_resp_o_r_bits_last,
    output logic [AXI_USER_WIDTH-1:0]    axi_resp_o_r_bits_user,
    input  logic                         axi_req_i_r_ready
);

    localparam int unsigned NB    = AXI_DATA_WIDTH / 8;
    localparam int unsigned OFF_W = $clog2(NB);
    localparam int unsigned WIN_W = OFF_W + $clog2(MEM_WORDS);

    state_t                       state_q, state_d;
    logic                         rd_pri_q, rd_pri_d;
    logic [AXI_ID_WIDTH-1:0]      id_q, id_d;
    logic [AXI_ADDRESS_WIDTH-1:0] addr_q, addr_d, next_addr, req_addr;
    beat_addr_t                   len_q, len_d, cnt_q, cnt_d;
    logic [2:0]                   size_q, size_d;
    burst_t                       burst_q, burst_d;
    logic                         oor_q, oor_d, werr_q, werr_d;
    logic [AXI_DATA_WIDTH-1:0]    mem_q [MEM_WORDS];
    logic                         sel_ar, idle, last_beat, w_hs;
    logic [1:0]                   req_burst;
    logic [WIN_W-OFF_W-1:0]       idx;
    logic                         unused;

    assign unused = ^{axi_req_i_aw_bits_lock, axi_req_i_aw_bits_cache, axi_req_i_aw_bits_prot,
                      axi_req_i_aw_bits_qos, axi_req_i_aw_bits_region, axi_req_i_aw_bits_user,
                      axi_req_i_ar_bits_lock, axi_req_i_ar_bits_cache, axi_req_i_ar_bits_prot,
                      axi_req_i_ar_bits_qos, axi_req_i_ar_bits_region, axi_req_i_ar_bits_user,
                      axi_req_i_w_bits_user};

    // Round-robin: read wins a tie only when the previous transaction was a write.
    assign sel_ar    = axi_req_i_ar_valid && (!axi_req_i_aw_valid || rd_pri_q);
    assign req_addr  = sel_ar ? axi_req_i_ar_bits_addr : axi_req_i_aw_bits_addr;
    assign req_burst = sel_ar ? axi_req_i_ar_bits_burst : axi_req_i_aw_bits_burst;
    assign idle      = rst_ni && (state_q == IDLE);
    assign last_beat = (cnt_q == len_q);
    assign idx       = addr_q[WIN_W-1:OFF_W];

    assign axi_resp_o_aw_ready = idle && !sel_ar;
    assign axi_resp_o_ar_ready = idle && sel_ar;
    assign axi_resp_o_w_ready  = rst_ni && (state_q == WDATA);
    assign axi_resp_o_b_valid  = rst_ni && (state_q == WRESP);
    assign axi_resp_o_r_valid  = rst_ni && (state_q == RDATA);
    assign w_hs                = axi_req_i_w_valid && axi_resp_o_w_ready;

    assign axi_resp_o_b_bits_id   = id_q;
    assign axi_resp_o_b_bits_resp = !axi_resp_o_b_valid ? RESP_OKAY
                                  : oor_q ? RESP_DECERR : werr_q ? RESP_SLVERR : RESP_OKAY;
    assign axi_resp_o_b_bits_user = '0;
    assign axi_resp_o_r_bits_id   = id_q;
    assign axi_resp_o_r_bits_data = (axi_resp_o_r_valid && !oor_q) ? mem_q[idx] : '0;
    assign axi_resp_o_r_bits_resp = (axi_resp_o_r_valid && oor_q) ? RESP_DECERR : RESP_OKAY;
    assign axi_resp_o_r_bits_last = axi_resp_o_r_valid && last_beat;
    assign axi_resp_o_r_bits_user = '0;

    axi_burst_addr_gen #(.ADDR_WIDTH(AXI_ADDRESS_WIDTH)) i_addr_gen (
        .addr_i      (addr_q),
        .len_i       (len_q),
        .size_i      (size_q),
        .burst_i     (burst_q),
        .next_addr_o (next_addr)
    );

    always_comb begin
        state_d  = state_q;
        rd_pri_d = rd_pri_q;
        id_d     = id_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        cnt_d    = cnt_q;
        oor_d    = oor_q;
        werr_d   = werr_q;
        unique case (state_q)
            IDLE: if (axi_req_i_aw_valid || axi_req_i_ar_valid) begin
                state_d  = sel_ar ? RDATA : WDATA;
                rd_pri_d = !sel_ar;
                id_d     = sel_ar ? axi_req_i_ar_bits_id : axi_req_i_aw_bits_id;
                addr_d   = req_addr;
                len_d    = sel_ar ? axi_req_i_ar_bits_len : axi_req_i_aw_bits_len;
                size_d   = sel_ar ? axi_req_i_ar_bits_size : axi_req_i_aw_bits_size;
                burst_d  = (req_burst == 2'b11) ? BURST_INCR : burst_t'(req_burst);
                cnt_d    = '0;
                oor_d    = req_addr[AXI_ADDRESS_WIDTH-1:WIN_W] != MEM_BASE[AXI_ADDRESS_WIDTH-1:WIN_W];
                werr_d   = 1'b0;
            end
            WDATA: if (axi_req_i_w_valid) begin
                addr_d  = next_addr;
                cnt_d   = cnt_q + 1'b1;
                werr_d  = werr_q || (axi_req_i_w_bits_last != last_beat);
                state_d = last_beat ? WRESP : WDATA;
            end
            WRESP: state_d = axi_req_i_b_ready ? IDLE : WRESP;
            RDATA: if (axi_req_i_r_ready) begin
                addr_d  = next_addr;
                cnt_d   = cnt_q + 1'b1;
                state_d = last_beat ? IDLE : RDATA;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            rd_pri_q <= 1'b0;
            id_q     <= '0;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= BURST_FIXED;
            cnt_q    <= '0;
            oor_q    <= 1'b0;
            werr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_pri_q <= rd_pri_d;
            id_q     <= id_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            cnt_q    <= cnt_d;
            oor_q    <= oor_d;
            werr_q   <= werr_d;
        end
    end

    // Storage keeps its contents across reset.
    always_ff @(posedge clk_i) begin
        if (w_hs && !oor_q) begin
            for (int b = 0; b < NB; b++) begin
                if (axi_req_i_w_bits_strb[b]) mem_q[idx][8*b +: 8] <= axi_req_i_w_bits_data[8*b +: 8];
            end
        end
    end

endmodule

// File: tb/tb_cva6_axi_mem_responder.sv
// tb_cva6_axi_mem_responder: directed and randomized bursts checked against a
// byte-level memory model with per-beat addresses computed arithmetically.
module tb_cva6_axi_mem_responder;

    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam int          WORDS = 1024;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        aw_valid, aw_ready, ar_valid, ar_ready;
    logic [3:0]  aw_id, ar_id, b_id, r_id;
    logic [63:0] aw_addr, ar_addr;
    logic [7:0]  aw_len, ar_len;
    logic [2:0]  aw_size, ar_size;
    logic [1:0]  aw_burst, ar_burst, b_resp, r_resp;
    logic        w_valid, w_last, w_ready, b_valid, b_ready, r_valid, r_ready, r_last;
    logic [63:0] w_data, r_data;
    logic [7:0]  w_strb;
    logic        b_user, r_user;

    logic [63:0] mem_m [WORDS];
    logic [63:0] wd [256];
    logic [7:0]  ws [256];
    int          checks = 0;
    int          errors = 0;

    cva6_axi_mem_responder dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .axi_req_i_aw_valid(aw_valid), .axi_req_i_aw_bits_id(aw_id), .axi_req_i_aw_bits_addr(aw_addr),
        .axi_req_i_aw_bits_len(aw_len), .axi_req_i_aw_bits_size(aw_size), .axi_req_i_aw_bits_burst(aw_burst),
        .axi_req_i_aw_bits_lock(1'b0), .axi_req_i_aw_bits_cache(4'h0), .axi_req_i_aw_bits_prot(3'h0),
        .axi_req_i_aw_bits_qos(4'h0), .axi_req_i_aw_bits_region(4'h0), .axi_req_i_aw_bits_user(1'b0),
        .axi_resp_o_aw_ready(aw_ready),
        .axi_req_i_w_valid(w_valid), .axi_req_i_w_bits_data(w_data), .axi_req_i_w_bits_strb(w_strb),
        .axi_req_i_w_bits_last(w_last), .axi_req_i_w_bits_user(1'b0), .axi_resp_o_w_ready(w_ready),
        .axi_resp_o_b_valid(b_valid), .axi_resp_o_b_bits_id(b_id), .axi_resp_o_b_bits_resp(b_resp),
        .axi_resp_o_b_bits_user(b_user), .axi_req_i_b_ready(b_ready),
        .axi_req_i_ar_valid(ar_valid), .axi_req_i_ar_bits_id(ar_id), .axi_req_i_ar_bits_addr(ar_addr),
        .axi_req_i_ar_bits_len(ar_len), .axi_req_i_ar_bits_size(ar_size), .axi_req_i_ar_bits_burst(ar_burst),
        .axi_req_i_ar_bits_lock(1'b0), .axi_req_i_ar_bits_cache(4'h0), .axi_req_i_ar_bits_prot(3'h0),
        .axi_req_i_ar_bits_qos(4'h0), .axi_req_i_ar_bits_region(4'h0), .axi_req_i_ar_bits_user(1'b0),
        .axi_resp_o_ar_ready(ar_ready),
        .axi_resp_o_r_valid(r_valid), .axi_resp_o_r_bits_id(r_id), .axi_resp_o_r_bits_data(r_data),
        .axi_resp_o_r_bits_resp(r_resp), .axi_resp_o_r_bits_last(r_last), .axi_resp_o_r_bits_user(r_user),
        .axi_req_i_r_ready(r_ready)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] beat_addr(input logic [63:0] a, input int len, input int size,
                                              input int burst, input int i);
        logic [63:0] step, al, wsz, lo;
        step = 64'd1 << size;
        al   = a - (a % step);
        if (i == 0 || burst == 0) return a;
        if (burst == 2) begin
            wsz = step * 64'(len + 1);
            lo  = al - (al % wsz);
            return lo + ((al - lo + step * 64'(i)) % wsz);
        end
        return al + step * 64'(i);
    endfunction

    function automatic bit in_win(input logic [63:0] a);
        return a >= BASE && a < BASE + 64'(WORDS * 8);
    endfunction

    function automatic int widx(input logic [63:0] a);
        return int'(((a - BASE) >> 3) % 64'(WORDS));
    endfunction

    task automatic send_aw(input logic [63:0] a, input int l, input int s, input int b,
                           input logic [3:0] id, output int waited);
        bit hs;
        hs = 0;
        waited = 0;
        aw_addr = a; aw_len = 8'(l); aw_size = 3'(s); aw_burst = 2'(b); aw_id = id; aw_valid = 1;
        w_valid = 1; w_data = wd[0]; w_strb = ws[0]; w_last = 0;
        while (!hs && waited < 20) begin
            #1 hs = aw_ready;
            if (hs) chk("w_ready_in_aw_cycle", w_ready, 0);
            @(negedge clk);
            if (!hs) waited++;
        end
        aw_valid = 0; w_valid = 0;
        chk("aw_handshake", hs, 1);
    endtask

    task automatic send_ar(input logic [63:0] a, input int l, input int s, input int b,
                           input logic [3:0] id, output int waited);
        bit hs;
        hs = 0;
        waited = 0;
        ar_addr = a; ar_len = 8'(l); ar_size = 3'(s); ar_burst = 2'(b); ar_id = id; ar_valid = 1;
        while (!hs && waited < 20) begin
            #1 hs = ar_ready;
            @(negedge clk);
            if (!hs) waited++;
        end
        ar_valid = 0;
        chk("ar_handshake", hs, 1);
    endtask

    task automatic send_w(input logic [63:0] a, input int l, input int s, input int b,
                          input logic [3:0] id, input int early);
        bit oor, bad;
        logic [63:0] ba;
        logic [1:0] er;
        oor = !in_win(a);
        bad = 0;
        for (int i = 0; i <= l; i++) begin
            w_valid = 1; w_data = wd[i]; w_strb = ws[i];
            w_last = (early >= 0) ? (i == early) : (i == l);
            if (w_last != (i == l)) bad = 1;
            #1 chk("w_ready", w_ready, 1);
            ba = beat_addr(a, l, s, b, i);
            if (!oor) for (int k = 0; k < 8; k++) if (ws[i][k]) mem_m[widx(ba)][8*k +: 8] = wd[i][8*k +: 8];
            @(negedge clk);
        end
        w_valid = 0; w_last = 0;
        er = oor ? 2'b11 : bad ? 2'b10 : 2'b00;
        #1 chk("b_valid_after_last_w", b_valid, 1);
        chk("b_resp", b_resp, er);
        chk("b_id", b_id, id);
        @(negedge clk);
        chk("b_held", {b_valid, b_resp, b_id}, {1'b1, er, id});
        b_ready = 1;
        @(negedge clk);
        b_ready = 0;
        #1 chk("b_done", b_valid, 0);
    endtask

    task automatic recv_r(input logic [63:0] a, input int l, input int s, input int b,
                          input logic [3:0] id, input int stall);
        bit oor;
        logic [63:0] ev;
        oor = !in_win(a);
        r_ready = 1;
        for (int i = 0; i <= l; i++) begin
            ev = oor ? 64'd0 : mem_m[widx(beat_addr(a, l, s, b, i))];
            if (i == stall) begin
                r_ready = 0;
                repeat (2) begin
                    #1 chk("r_stall_held", {r_valid, r_data}, {1'b1, ev});
                    @(negedge clk);
                end
                r_ready = 1;
            end
            #1 chk("r_valid", r_valid, 1);
            chk("r_data", r_data, ev);
            chk("r_resp", r_resp, oor ? 2'b11 : 2'b00);
            chk("r_last", r_last, i == l);
            chk("r_id", r_id, id);
            @(negedge clk);
        end
        r_ready = 0;
        #1 chk("r_done", r_valid, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        aw_valid = 0; ar_valid = 0; w_valid = 0; w_last = 0; b_ready = 0; r_ready = 0;
        aw_addr = 0; aw_id = 0; aw_len = 0; aw_size = 0; aw_burst = 0;
        ar_addr = 0; ar_id = 0; ar_len = 0; ar_size = 0; ar_burst = 0;
        w_data = 0; w_strb = 0;
        repeat (3) @(negedge clk);
        #1 chk("reset_readys", {aw_ready, ar_ready, w_ready}, 3'b000);
        chk("reset_valids", {b_valid, r_valid, r_last}, 3'b000);
        chk("reset_fields", {b_id, b_resp, r_id, r_resp, r_data, b_user, r_user}, '0);
        @(negedge clk);
        rst_ni = 1;
        #1 chk("idle_after_reset", {aw_ready, ar_ready}, 2'b10);
        @(negedge clk);

        // Fill the whole window so every later read has a known expectation.
        for (int blk = 0; blk < 4; blk++) begin
            for (int i = 0; i < 256; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; end
            send_aw(BASE + 64'(blk * 2048), 255, 3, 1, 4'(blk), w);
            send_w(BASE + 64'(blk * 2048), 255, 3, 1, 4'(blk), -1);
        end

        wd[0] = 64'hDEAD_BEEF_0123_4567; ws[0] = 8'hFF;
        send_aw(BASE + 64'h10, 0, 3, 1, 4'h1, w);
        send_w(BASE + 64'h10, 0, 3, 1, 4'h1, -1);
        send_ar(BASE + 64'h10, 0, 3, 1, 4'h2, w);
        recv_r(BASE + 64'h10, 0, 3, 1, 4'h2, -1);

        for (int i = 0; i < 4; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = (i == 2) ? 8'h0F : 8'hFF; end
        send_aw(BASE, 3, 3, 1, 4'h3, w);
        send_w(BASE, 3, 3, 1, 4'h3, -1);
        send_ar(BASE, 3, 3, 1, 4'h3, w);
        recv_r(BASE, 3, 3, 1, 4'h3, -1);

        send_ar(BASE + 64'h18, 3, 3, 2, 4'hA, w);
        recv_r(BASE + 64'h18, 3, 3, 2, 4'hA, 2);

        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        send_aw(64'h7FFF_FFF8, 0, 3, 1, 4'h4, w);
        send_w(64'h7FFF_FFF8, 0, 3, 1, 4'h4, -1);
        send_ar(BASE + 64'(WORDS * 8), 0, 3, 1, 4'h5, w);
        recv_r(BASE + 64'(WORDS * 8), 0, 3, 1, 4'h5, -1);
        send_ar(BASE + 64'(WORDS * 8 - 8), 0, 3, 1, 4'h6, w);
        recv_r(BASE + 64'(WORDS * 8 - 8), 0, 3, 1, 4'h6, -1);

        for (int t = 0; t < 24; t++) begin
            int s, b, l;
            logic [63:0] a, st;
            logic [3:0] id;
            b  = $urandom_range(0, 3);
            s  = $urandom_range(0, 3);
            l  = (b == 2) ? (2 << $urandom_range(0, 3)) - 1 : $urandom_range(0, 15);
            st = 64'd1 << s;
            a  = (BASE + 64'($urandom_range(0, WORDS * 8 - 1))) & ~(st - 64'd1);
            id = 4'($urandom);
            for (int i = 0; i <= l; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom); end
            if ($urandom_range(0, 1) == 1) begin
                send_aw(a, l, s, b, id, w);
                send_w(a, l, s, b, id, -1);
            end else begin
                send_ar(a, l, s, b, id, w);
                recv_r(a, l, s, b, id, ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, l)) : -1);
            end
        end

        // Abandon a read mid-burst; release reset with both address channels pending.
        send_ar(BASE, 7, 3, 1, 4'h5, w);
        r_ready = 1;
        repeat (2) @(negedge clk);
        #2 rst_ni = 0;
        #1 chk("reset_async_r_valid", r_valid, 0);
        r_ready = 0;
        aw_addr = BASE + 64'h40; aw_len = 1; aw_size = 3; aw_burst = 1; aw_id = 4'h6; aw_valid = 1;
        ar_addr = BASE + 64'h40; ar_len = 1; ar_size = 3; ar_burst = 1; ar_id = 4'h7; ar_valid = 1;
        #1 chk("reset_readys_pending", {aw_ready, ar_ready, w_ready, r_valid}, 4'b0000);
        @(negedge clk);
        rst_ni = 1;
        #1 chk("rr_write_first_after_reset", {aw_ready, ar_ready, r_valid}, 3'b100);
        wd[0] = {$urandom, $urandom}; wd[1] = {$urandom, $urandom}; ws[0] = 8'hFF; ws[1] = 8'hFF;
        send_aw(BASE + 64'h40, 1, 3, 1, 4'h6, w);
        chk("aw_immediate", w, 0);
        send_w(BASE + 64'h40, 1, 3, 1, 4'h6, 0);
        send_ar(BASE + 64'h40, 1, 3, 1, 4'h7, w);
        chk("ar_in_first_idle_cycle", w, 0);
        recv_r(BASE + 64'h40, 1, 3, 1, 4'h7, -1);

        aw_addr = BASE + 64'h80; aw_len = 0; aw_size = 3; aw_burst = 1; aw_id = 4'h8; aw_valid = 1;
        ar_addr = BASE + 64'h80; ar_len = 0; ar_size = 3; ar_burst = 1; ar_id = 4'h9; ar_valid = 1;
        #1 chk("rr_write_after_read", {aw_ready, ar_ready}, 2'b10);
        wd[0] = {$urandom, $urandom}; ws[0] = 8'hFF;
        send_aw(BASE + 64'h80, 0, 3, 1, 4'h8, w);
        send_w(BASE + 64'h80, 0, 3, 1, 4'h8, -1);
        aw_addr = BASE + 64'h88; aw_len = 0; aw_size = 3; aw_burst = 1; aw_id = 4'hB; aw_valid = 1;
        #1 chk("rr_read_after_write", {aw_ready, ar_ready}, 2'b01);
        send_ar(BASE + 64'h80, 0, 3, 1, 4'h9, w);
        recv_r(BASE + 64'h80, 0, 3, 1, 4'h9, -1);
        wd[0] = {$urandom, $urandom}; ws[0] = 8'h3C;
        send_aw(BASE + 64'h88, 0, 3, 1, 4'hB, w);
        chk("aw_after_read_immediate", w, 0);
        send_w(BASE + 64'h88, 0, 3, 1, 4'hB, -1);
        send_ar(BASE, 7, 3, 1, 4'hC, w);
        recv_r(BASE, 7, 3, 1, 4'hC, -1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
